uart_to_ram: RTL and testbench
==============================

UART_TO_RAM -- requirements
Module: uart_to_ram

Interface
- REQ-001 SHALL have parameter RAM_SIZE, default PACKET_BUFFER_SIZE: depth of the target RAM in bytes; address width is clog2(RAM_SIZE).
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200 baud).
- REQ-003 SHALL have port clk, input, 1: the single clock; all logic runs on its rising edge.
- REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port rxd, input, 1: asynchronous UART serial line, idle high.
- REQ-006 SHALL have port start, input, 1: single-cycle pulse that arms a capture.
- REQ-007 SHALL have ports write_start and write_end, input, clog2(RAM_SIZE) each: first address, and one past the last address, like C.
- REQ-008 SHALL have port ram_write_enable, output, 1: one-cycle write strobe to the RAM driver.
- REQ-009 SHALL have port ram_write_addr, output, clog2(RAM_SIZE): address qualified by ram_write_enable.
- REQ-010 SHALL have port ram_write_val, output, BYTE_LEN: data qualified by ram_write_enable.
- REQ-011 SHALL have port busy, output, 1: high while a capture is armed.
- REQ-012 SHALL have port done, output, 1: one-cycle pulse when a capture completes.
- REQ-013 SHALL have port frame_err, output, 1: sticky bad-frame flag, cleared by start.

Function
- REQ-014 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all sampling uses the synchronized value.
- REQ-015 SHALL use the states IDLE, WAIT_START, START_BIT, DATA_BITS, PARITY_BIT (only when the parity feature is compiled in) and STOP_BIT.
- REQ-016 SHALL, in IDLE on start, latch write_end, load the address from write_start, clear frame_err, set busy and enter WAIT_START; if write_start == write_end it SHALL instead pulse done on the next cycle and perform no writes.
- REQ-017 SHALL, in WAIT_START, enter START_BIT on a synchronized high-to-low transition of rxd.
- REQ-018 SHALL, in START_BIT, resample rxd after CLKS_PER_BIT/2 cycles: low enters DATA_BITS, high (a glitch) returns to WAIT_START with no error.
- REQ-019 SHALL sample 8 data bits at CLKS_PER_BIT intervals from mid-start, LSB first.
- REQ-020 SHALL sample the stop bit at mid-bit: high accepts the byte, low discards it, sets frame_err and returns to WAIT_START.
- REQ-021 SHALL, one cycle after an accepted stop-bit sample, assert ram_write_enable for exactly one cycle with the current address and the received byte.
- REQ-022 SHALL advance the address by 1 modulo 2^clog2(RAM_SIZE) after each write; write_end == RAM_SIZE therefore wraps to 0.
- REQ-023 SHALL, when the incremented address equals the latched end, pulse done on the cycle after the write, drop busy in that same cycle and return to IDLE; otherwise it returns to WAIT_START.
- REQ-024 SHALL treat start while busy as a restart: the in-flight byte is aborted without a write and REQ-016 reapplies.
- REQ-025 SHALL ignore rxd activity while in IDLE.
- REQ-026 SHALL hold ram_write_addr and ram_write_val stable while ram_write_enable is low.

Reset
- REQ-027 SHALL, on reset low and independent of clk, force state IDLE and set busy, done, ram_write_enable and frame_err to 0, ram_write_addr and ram_write_val to 0, and the synchronizer flops to 1.
- REQ-028 SHALL, on reset asserted mid-byte, drop the partial byte and perform no write.

Configuration
- REQ-029 SHALL, with macro UART_TO_RAM_PARITY_EN defined, expect an even-parity bit between data and stop; on mismatch the byte SHALL be discarded and frame_err set.
- REQ-030 SHALL, without UART_TO_RAM_PARITY_EN, contain no parity state or logic and treat the 10th bit as the stop bit.

Verification (bench uses CLKS_PER_BIT=8, RAM_SIZE=16)
- REQ-031 SHALL cover a single byte: write_start=3, write_end=4, send 0xA5 -> one write of addr 3 / 0xA5, then done pulse, then busy=0.
- REQ-032 SHALL cover wrap-around: write_start=14, write_end=1, send 0x11, 0x22, 0x33 -> writes to addr 14, 15, 0, then done.
- REQ-033 SHALL cover a framing error: send 0x5A with stop bit low, then 0x5B -> no write for 0x5A, frame_err=1, 0x5B written to write_start.
- REQ-034 SHALL cover a glitch: 2-cycle low pulse on rxd -> no write, frame_err stays 0, block still in WAIT_START.
- REQ-035 SHALL cover the empty range: write_start=write_end=7 with start -> done one cycle later, no ram_write_enable.
- REQ-036 SHALL cover reset mid-byte: reset low during data bit 4 -> all outputs 0 immediately, no write; a new start then captures 0xC3 correctly.

Source files
------------

// File: rtl/uart_to_ram_if.sv
// uart_to_ram_if: RAM write-port bundle driven by uart_to_ram.
// The master side issues one-cycle write strobes with address and data;
// the slave side is the RAM driver.
interface uart_to_ram_if #(
  parameter int ADDR_W   = 8,
  parameter int BYTE_LEN = 8
);
  logic                ram_write_enable;
  logic [ADDR_W-1:0]   ram_write_addr;
  logic [BYTE_LEN-1:0] ram_write_val;

  modport master (
    output ram_write_enable,
    output ram_write_addr,
    output ram_write_val
  );

  modport slave (
    input ram_write_enable,
    input ram_write_addr,
    input ram_write_val
  );
endinterface

// File: rtl/uart_to_ram.sv
// uart_to_ram: receives 8N1 UART bytes on rxd and writes them to consecutive
// RAM addresses in [write_start, write_end), wrapping modulo 2^clog2(RAM_SIZE).
// A capture is armed by a one-cycle start pulse; done pulses when the range
// is full. Bad frames are dropped and flagged on the sticky frame_err.
// Optional feature macro: UART_TO_RAM_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
`ifndef PACKET_BUFFER_SIZE
`define PACKET_BUFFER_SIZE 256
`endif

module uart_to_ram #(
  parameter  int RAM_SIZE     = `PACKET_BUFFER_SIZE,
  parameter  int CLKS_PER_BIT = 434,
  localparam int ADDR_W       = $clog2(RAM_SIZE),
  localparam int BYTE_LEN     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  input  logic              start,
  input  logic [ADDR_W-1:0] write_start,
  input  logic [ADDR_W-1:0] write_end,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  uart_to_ram_if.master     ram_wr
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START_BIT,
    DATA_BITS,
`ifdef UART_TO_RAM_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } state_t;

  state_t              state_q, state_d;

  logic                rxd_meta, rxd_s, rxd_prev;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          bit_idx_q;
  logic [BYTE_LEN-1:0] shreg_q;
  logic [ADDR_W-1:0]   addr_q, end_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [BYTE_LEN-1:0] wr_val_q;

  logic rx_fall;
  logic bit_tick;
  logic cap_load, cap_empty, cap_finish;
  logic byte_ok, byte_bad;

  assign rx_fall = rxd_prev & ~rxd_s;

  assign ram_wr.ram_write_enable = wr_en_q;
  assign ram_wr.ram_write_addr   = wr_addr_q;
  assign ram_wr.ram_write_val    = wr_val_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and one-cycle action strobes; start always wins.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cap_load   = 1'b0;
    cap_empty  = 1'b0;
    cap_finish = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    bit_tick   = (state_q == START_BIT) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    if (start) begin
      if (write_start == write_end) begin
        cap_empty = 1'b1;
        state_d   = IDLE;
      end else begin
        cap_load = 1'b1;
        state_d  = WAIT_START;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_START: begin
          if (wr_en_q && (addr_q == end_q)) begin
            cap_finish = 1'b1;
            state_d    = IDLE;
          end else if (rx_fall) begin
            state_d = START_BIT;
          end
        end
        START_BIT: begin
          if (bit_tick) state_d = rxd_s ? WAIT_START : DATA_BITS;
        end
        DATA_BITS: begin
`ifdef UART_TO_RAM_PARITY_EN
          if (bit_tick && (bit_idx_q == 3'd7)) state_d = PARITY_BIT;
`else
          if (bit_tick && (bit_idx_q == 3'd7)) state_d = STOP_BIT;
`endif
        end
`ifdef UART_TO_RAM_PARITY_EN
        PARITY_BIT: begin
          if (bit_tick) begin
            if ((^shreg_q) ^ rxd_s) begin
              byte_bad = 1'b1;
              state_d  = WAIT_START;
            end else begin
              state_d = STOP_BIT;
            end
          end
        end
`endif
        STOP_BIT: begin
          if (bit_tick) begin
            state_d  = WAIT_START;
            byte_ok  = rxd_s;
            byte_bad = ~rxd_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizer, bit timing, shift register, address and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta  <= 1'b1;
      rxd_s     <= 1'b1;
      rxd_prev  <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      addr_q    <= '0;
      end_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;

      done    <= 1'b0;
      wr_en_q <= 1'b0;

      // Bit timer restarts on every state change and on every sample point.
      if ((state_d != state_q) || bit_tick) cnt_q <= '0;
      else                                  cnt_q <= cnt_q + CNT_W'(1);

      if ((state_d == DATA_BITS) && (state_q != DATA_BITS)) begin
        bit_idx_q <= '0;
      end else if ((state_q == DATA_BITS) && bit_tick) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        shreg_q   <= {rxd_s, shreg_q[BYTE_LEN-1:1]};
      end

      if (cap_load) begin
        addr_q    <= write_start;
        end_q     <= write_end;
        frame_err <= 1'b0;
        busy      <= 1'b1;
      end

      if (cap_empty) begin
        frame_err <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end

      if (cap_finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if (byte_bad) frame_err <= 1'b1;

      // Write address/data only change together with the strobe.
      if (byte_ok) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q;
        wr_val_q  <= shreg_q;
        addr_q    <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_to_ram.sv
// tb_uart_to_ram: directed bench for uart_to_ram (RAM_SIZE=16, CLKS_PER_BIT=8).
// Expected writes go into a scoreboard queue when a byte is sent and are
// popped and compared when the DUT strobes ram_write_enable.
module tb_uart_to_ram;

  localparam int CPB    = 8;
  localparam int RSIZE  = 16;
  localparam int AW     = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          rxd;
  logic          start;
  logic [AW-1:0] write_start;
  logic [AW-1:0] write_end;
  logic          busy;
  logic          done;
  logic          frame_err;

  uart_to_ram_if #(.ADDR_W(AW), .BYTE_LEN(8)) ram_wr ();

  uart_to_ram #(.RAM_SIZE(RSIZE), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .start       (start),
    .write_start (write_start),
    .write_end   (write_end),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err),
    .ram_wr      (ram_wr)
  );

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  last_wr_cyc = -1;
  int  last_done_cyc = -1;
  int  start_cyc = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every write strobe, record done pulses.
  always @(negedge clk) begin
    if (ram_wr.ram_write_enable === 1'b1) begin
      wr_t e;
      check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_wr.ram_write_addr), 32'(e.addr));
        check("wr_val", 32'(ram_wr.ram_write_val), 32'(e.data));
      end
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] ws, input logic [AW-1:0] we);
    @(negedge clk);
    write_start = ws;
    write_end   = we;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(CPB);
  endtask

  // Full frame followed by one idle bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_TO_RAM_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
    send_bit(1'b1);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  int wr0, done0;

  initial begin
    reset       = 1'b0;
    rxd         = 1'b1;
    start       = 1'b0;
    write_start = '0;
    write_end   = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_wr_en", 32'(ram_wr.ram_write_enable), 32'd0);
    check("rst_wr_addr", 32'(ram_wr.ram_write_addr), 32'd0);
    check("rst_wr_val", 32'(ram_wr.ram_write_val), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    // rxd activity while idle must not produce writes.
    send_byte(8'h3C, 1'b1);
    check("idle_ignores_rxd_writes", 32'(wr_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single byte: addr 3, A5, then done, then not busy.
    pulse_start(4'd3, 4'd4);
    check("single_busy_armed", 32'(busy), 32'd1);
    expect_wr(4'd3, 8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(2);
    check("single_wr_cnt", 32'(wr_cnt), 32'd1);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    check("single_done_after_wr", 32'(last_done_cyc - last_wr_cyc), 32'd1);
    check("single_busy_clear", 32'(busy), 32'd0);

    // Wrap-around: 14, 15, 0 then done.
    pulse_start(4'd14, 4'd1);
    expect_wr(4'd14, 8'h11);
    send_byte(8'h11, 1'b1);
    expect_wr(4'd15, 8'h22);
    send_byte(8'h22, 1'b1);
    check("wrap_busy_mid", 32'(busy), 32'd1);
    check("wrap_no_early_done", 32'(done_cnt), 32'd1);
    expect_wr(4'd0, 8'h33);
    send_byte(8'h33, 1'b1);
    idle(2);
    check("wrap_wr_cnt", 32'(wr_cnt), 32'd4);
    check("wrap_done_cnt", 32'(done_cnt), 32'd2);
    check("wrap_done_after_wr", 32'(last_done_cyc - last_wr_cyc), 32'd1);
    check("wrap_busy_clear", 32'(busy), 32'd0);

    // Framing error: bad 0x5A dropped, 0x5B lands at write_start.
    pulse_start(4'd5, 4'd7);
    send_byte(8'h5A, 1'b0);
    check("frame_err_set", 32'(frame_err), 32'd1);
    check("frame_no_write", 32'(wr_cnt), 32'd4);
    expect_wr(4'd5, 8'h5B);
    send_byte(8'h5B, 1'b1);
    check("frame_good_written", 32'(wr_cnt), 32'd5);
    check("frame_err_sticky", 32'(frame_err), 32'd1);
    check("frame_still_busy", 32'(busy), 32'd1);

    // Glitch: restart clears frame_err; 2-cycle low pulse is ignored.
    pulse_start(4'd8, 4'd10);
    check("restart_clears_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(3 * CPB);
    check("glitch_no_write", 32'(wr_cnt), 32'd5);
    check("glitch_no_frame_err", 32'(frame_err), 32'd0);
    check("glitch_busy", 32'(busy), 32'd1);
    expect_wr(4'd8, 8'h77);
    send_byte(8'h77, 1'b1);
    check("glitch_then_byte", 32'(wr_cnt), 32'd6);
    check("glitch_busy_after", 32'(busy), 32'd1);

    // Empty range (also restarts the armed capture): done next cycle only.
    done0 = done_cnt;
    pulse_start(4'd7, 4'd7);
    idle(2);
    check("empty_done_cnt", 32'(done_cnt - done0), 32'd1);
    check("empty_done_timing", 32'(last_done_cyc - start_cyc), 32'd1);
    check("empty_no_write", 32'(wr_cnt), 32'd6);
    check("empty_busy", 32'(busy), 32'd0);

    // Reset during data bit 4, then a clean capture of 0xC3.
    pulse_start(4'd2, 4'd3);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    idle(3);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_wr_addr", 32'(ram_wr.ram_write_addr), 32'd0);
    check("midrst_wr_val", 32'(ram_wr.ram_write_val), 32'd0);
    check("midrst_wr_en", 32'(ram_wr.ram_write_enable), 32'd0);
    idle(3);
    reset = 1'b1;
    idle(2 * CPB);
    check("midrst_no_write", 32'(wr_cnt), 32'd6);
    wr0   = wr_cnt;
    done0 = done_cnt;
    pulse_start(4'd2, 4'd3);
    expect_wr(4'd2, 8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(2);
    check("postrst_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    check("postrst_done", 32'(done_cnt - done0), 32'd1);
    check("postrst_busy", 32'(busy), 32'd0);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
